// File: rtl/uart_tx_queue.sv
// Byte FIFO plus launch controller feeding a UART transmitter, one frame at a time.
// Optional sticky overflow flag (ovf/ovf_clr) is enabled by defining UART_TXQ_OVF_EN.
module uart_tx_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [DATA_W-1:0] tx_din,
    output logic              tx_start,
    input  logic              tx_done_tick,
`ifdef UART_TXQ_OVF_EN
    output logic              ovf,
    input  logic              ovf_clr,
`endif
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = DEPTH[ADDR_W:0];

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [0:0]        state;
    logic              push;
    logic              pop;

    assign full  = (count == FULL_LEVEL);
    assign empty = (count == '0);
    assign level = count;
    assign busy  = (state == WAIT) | ~empty;

    // A pop is simply the IDLE state seeing a non-empty queue; full blocks pushes regardless of pop.
    assign push = wr_en & ~full;
    assign pop  = (state == IDLE) & ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // tx_din is only loaded at launch so it stays stable for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (pop) begin
                        tx_din   <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    tx_start <= 1'b0;
                    if (tx_done_tick) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_EN
    // Set has priority over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule
